// File: rtl/audio_mix_scheduler.sv
// Time-multiplexed audio mixer: one shared multiplier walks NCH channels per sample strobe.
// Optional master-volume fade instead of hard mute when AUDIO_MUTE_RAMP_EN is defined.
module audio_mix_scheduler #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int GW  = 8,
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic [NCH*W-1:0] i_ch_in,
  input  logic             i_enable,
  input  logic             i_gain_we,
  input  logic [AW-1:0]    i_gain_addr,
  input  logic [GW-1:0]    i_gain_wdata,
  output logic [15:0]      o_out,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int PW   = W + GW;
  localparam int ACCW = W + GW + 3;
  localparam int SW   = W + 3;
  localparam logic [GW-1:0] GAIN_RST = GW'(1) << (GW - 1);

`ifdef AUDIO_MUTE_RAMP_EN
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_MAC, S_RAMP, S_FINISH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_MAC, S_FINISH} state_t;
`endif

  state_t          r_state;
  logic [GW-1:0]   r_gain    [NCH];
  logic [GW-1:0]   r_sh_gain [NCH];
  logic [W-1:0]    r_sh_ch   [NCH];
  logic [ACCW-1:0] r_acc;
  logic [AW-1:0]   r_idx;

  logic [W-1:0]    w_ch [NCH];
  logic [PW-1:0]   w_prod;
  logic [SW-1:0]   w_sum;

  function automatic logic [15:0] sat16(input logic [SW-1:0] s);
    if (32'(s) > 32'h0000_FFFF) begin
      return 16'hFFFF;
    end else begin
      return 16'(s);
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_ch[i] = i_ch_in[i*W +: W];
    end
  end

  assign w_prod = PW'(r_sh_ch[r_idx]) * PW'(r_sh_gain[r_idx]);
  assign w_sum  = SW'(r_acc >> GW);
  assign o_busy = (r_state != S_IDLE);

`ifdef AUDIO_MUTE_RAMP_EN
  logic [7:0]    r_mvol;
  logic [SW-1:0] r_scaled;
  logic [7:0]    w_mvol_next;
  logic [SW+7:0] w_vol_prod;

  // One volume step per frame toward full scale or silence.
  always_comb begin
    w_mvol_next = r_mvol;
    if (i_enable) begin
      if (r_mvol != 8'hFF) begin
        w_mvol_next = r_mvol + 8'd1;
      end else begin
        w_mvol_next = r_mvol;
      end
    end else begin
      if (r_mvol != 8'h00) begin
        w_mvol_next = r_mvol - 8'd1;
      end else begin
        w_mvol_next = r_mvol;
      end
    end
  end

  assign w_vol_prod = (SW+8)'(w_sum) * (SW+8)'(w_mvol_next);
`endif

  // CPU gain registers; writes land regardless of frame state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_gain[i] <= GAIN_RST;
      end
    end else if (i_gain_we && (32'(i_gain_addr) < NCH)) begin
      r_gain[i_gain_addr] <= i_gain_wdata;
    end
  end

  // Frame sequencer: snapshot, multiply-accumulate, scale/saturate, publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      o_out       <= 16'h0000;
      o_out_valid <= 1'b0;
      o_overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_sh_ch[i]   <= '0;
        r_sh_gain[i] <= '0;
      end
`ifdef AUDIO_MUTE_RAMP_EN
      r_mvol   <= 8'h00;
      r_scaled <= '0;
`endif
    end else begin
      o_out_valid <= 1'b0;
      // Only IDLE accepts a strobe; anything else is a dropped sample.
      if (i_sample_en && (r_state != S_IDLE)) begin
        o_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_sample_en) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          for (int i = 0; i < NCH; i++) begin
            r_sh_ch[i]   <= w_ch[i];
            r_sh_gain[i] <= r_gain[i];
          end
          r_acc   <= '0;
          r_idx   <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= r_acc + ACCW'(w_prod);
          if (r_idx == AW'(NCH - 1)) begin
`ifdef AUDIO_MUTE_RAMP_EN
            r_state <= S_RAMP;
`else
            r_state <= S_FINISH;
`endif
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
`ifdef AUDIO_MUTE_RAMP_EN
        S_RAMP: begin
          r_mvol   <= w_mvol_next;
          r_scaled <= SW'(w_vol_prod >> 8);
          r_state  <= S_FINISH;
        end
        S_FINISH: begin
          o_out       <= sat16(r_scaled);
          o_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
`else
        S_FINISH: begin
          o_out       <= i_enable ? sat16(w_sum) : 16'h0000;
          o_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Self-checking bench for audio_mix_scheduler: table vectors, corner sequences, random frames.
module tb_audio_mix_scheduler;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int GW  = 8;
  localparam int AW  = 2;
`ifdef AUDIO_MUTE_RAMP_EN
  localparam int LAT = NCH + 3;
`else
  localparam int LAT = NCH + 2;
`endif

  logic             clk;
  logic             rst;
  logic             i_sample_en;
  logic [NCH*W-1:0] i_ch_in;
  logic             i_enable;
  logic             i_gain_we;
  logic [AW-1:0]    i_gain_addr;
  logic [GW-1:0]    i_gain_wdata;
  logic [15:0]      o_out;
  logic             o_out_valid;
  logic             o_busy;
  logic             o_overrun;

  audio_mix_scheduler #(.NCH(NCH), .W(W), .GW(GW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_sample_en  (i_sample_en),
    .i_ch_in      (i_ch_in),
    .i_enable     (i_enable),
    .i_gain_we    (i_gain_we),
    .i_gain_addr  (i_gain_addr),
    .i_gain_wdata (i_gain_wdata),
    .o_out        (o_out),
    .o_out_valid  (o_out_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: what the bench believes gains / channels / volume are.
  int unsigned m_gain [NCH];
  logic [15:0] ch_v   [NCH];
  int          m_mvol;

  typedef struct packed {
    logic [NCH*16-1:0] ch;
    logic [NCH*8-1:0]  g;
    logic              en;
    logic [15:0]       exp_out;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Mixing rule from plain arithmetic: weighted sum, scale by 2^-GW, volume/mute, clip.
  function automatic logic [15:0] ref_mix(input bit en);
    longint sum = 0;
    for (int i = 0; i < NCH; i++) sum += longint'(ch_v[i]) * longint'(m_gain[i]);
    sum = sum / 256;
`ifdef AUDIO_MUTE_RAMP_EN
    if (en) m_mvol = (m_mvol < 255) ? m_mvol + 1 : 255;
    else    m_mvol = (m_mvol > 0) ? m_mvol - 1 : 0;
    sum = (sum * m_mvol) / 256;
`else
    if (!en) sum = 0;
`endif
    if (sum > 65535) return 16'hFFFF;
    return 16'(sum);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) m_gain[i] = 32'd128;
    m_mvol = 0;
  endtask

  task automatic write_gain(input int addr, input logic [7:0] data);
    i_gain_we    = 1'b1;
    i_gain_addr  = AW'(addr);
    i_gain_wdata = data;
    @(posedge clk); #1;
    i_gain_we = 1'b0;
    m_gain[addr] = data;
  endtask

  task automatic drive_ch();
    for (int i = 0; i < NCH; i++) i_ch_in[i*W +: W] = ch_v[i];
  endtask

  // One full frame: strobe, bounded wait for out_valid, check latency/value/idle.
  task automatic run_frame(input string name, input bit en, output logic [15:0] got);
    logic [15:0] exp;
    int  n;
    bit  seen;
    exp = ref_mix(en);
    i_enable = en;
    drive_ch();
    i_sample_en = 1'b1;
    @(posedge clk); #1;
    i_sample_en = 1'b0;
    check({name, "_busy"}, 32'(o_busy), 32'd1);
    n = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (o_out_valid) seen = 1'b1;
    end
    check({name, "_latency"}, seen ? 32'(n) : 32'hDEAD, 32'(LAT));
    check({name, "_out"}, 32'(o_out), 32'(exp));
    got = o_out;
    @(posedge clk); #1;
    check({name, "_idle"}, {30'd0, o_out_valid, o_busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] exp_old;
    int          nv;

    tbl[0] = '{ch: {4{16'h4000}}, g: {4{8'h80}}, en: 1'b1, exp_out: 16'h8000};
    tbl[1] = '{ch: {16'h0, 16'h0, 16'h0, 16'hFFFF}, g: {8'h0, 8'h0, 8'h0, 8'hFF}, en: 1'b1, exp_out: 16'hFEFF};
    tbl[2] = '{ch: {4{16'hFFFF}}, g: {4{8'hFF}}, en: 1'b1, exp_out: 16'hFFFF};
    tbl[3] = '{ch: {16'h4000, 16'h3000, 16'h2000, 16'h1000}, g: {8'h80, 8'h40, 8'h20, 8'h10}, en: 1'b1, exp_out: 16'h3100};
    tbl[4] = '{ch: {4{16'h4000}}, g: {4{8'h80}}, en: 1'b0, exp_out: 16'h0000};
    tbl[5] = '{ch: {4{16'hFFFF}}, g: {4{8'h80}}, en: 1'b1, exp_out: 16'hFFFF};
    tbl[6] = '{ch: {4{16'h0001}}, g: {4{8'hFF}}, en: 1'b1, exp_out: 16'h0003};

    rst = 1'b1; i_sample_en = 1'b0; i_ch_in = '0; i_enable = 1'b1;
    i_gain_we = 1'b0; i_gain_addr = '0; i_gain_wdata = '0;
    do_reset();
    check("rst_out", 32'(o_out), 32'd0);
    check("rst_flags", {29'd0, o_out_valid, o_busy, o_overrun}, 32'd0);

    // Default gains first, then table vectors with explicit gains.
    for (int i = 0; i < NCH; i++) ch_v[i] = 16'h4000;
    run_frame("default_gain", 1'b1, got);
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NCH; i++) begin
        write_gain(i, tbl[v].g[i*8 +: 8]);
        ch_v[i] = tbl[v].ch[i*16 +: 16];
      end
      run_frame($sformatf("tbl%0d", v), tbl[v].en, got);
`ifndef AUDIO_MUTE_RAMP_EN
      check($sformatf("tbl%0d_const", v), 32'(got), 32'(tbl[v].exp_out));
`endif
    end
    check("no_overrun_yet", 32'(o_overrun), 32'd0);

    // Second strobe at t+2 is dropped, one output only, overrun sticks.
    for (int i = 0; i < NCH; i++) begin ch_v[i] = 16'h2000 * 16'(i + 1); write_gain(i, 8'h80); end
    exp_old = ref_mix(1'b1);
    i_enable = 1'b1; drive_ch();
    i_sample_en = 1'b1; @(posedge clk); #1;
    i_sample_en = 1'b0; @(posedge clk); #1;
    i_sample_en = 1'b1; @(posedge clk); #1;
    i_sample_en = 1'b0;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_out_valid) begin nv++; check("ovr_out", 32'(o_out), 32'(exp_old)); end
      @(posedge clk); #1;
    end
    check("ovr_valid_count", 32'(nv), 32'd1);
    check("ovr_set", 32'(o_overrun), 32'd1);
    run_frame("ovr_after", 1'b1, got);
    check("ovr_sticky", 32'(o_overrun), 32'd1);
    do_reset();
    check("ovr_cleared", 32'(o_overrun), 32'd0);

    // Strobe landing on the FINISH edge is dropped too.
    for (int i = 0; i < NCH; i++) ch_v[i] = 16'h1234;
    exp_old = ref_mix(1'b1);
    drive_ch();
    i_sample_en = 1'b1; @(posedge clk); #1;
    i_sample_en = 1'b0;
    for (int c = 0; c < LAT - 1; c++) begin @(posedge clk); #1; end
    i_sample_en = 1'b1; @(posedge clk); #1;
    i_sample_en = 1'b0;
    check("fin_valid", 32'(o_out_valid), 32'd1);
    check("fin_out", 32'(o_out), 32'(exp_old));
    check("fin_overrun", 32'(o_overrun), 32'd1);
    nv = 0;
    for (int c = 0; c < 15; c++) begin @(posedge clk); #1; if (o_out_valid) nv++; end
    check("fin_no_second", 32'(nv), 32'd0);
    do_reset();

    // Gain written during MAC applies only to the next frame.
    for (int i = 0; i < NCH; i++) ch_v[i] = 16'h1000;
    write_gain(1, 8'h10);
    exp_old = ref_mix(1'b1);
    drive_ch();
    i_sample_en = 1'b1; @(posedge clk); #1;
    i_sample_en = 1'b0; @(posedge clk); #1;
    i_gain_we = 1'b1; i_gain_addr = 2'd1; i_gain_wdata = 8'hF0;
    @(posedge clk); #1;
    i_gain_we = 1'b0;
    nv = 0;
    while (nv < 20 && !o_out_valid) begin @(posedge clk); #1; nv++; end
    check("midgain_valid", 32'(o_out_valid), 32'd1);
    check("midgain_old", 32'(o_out), 32'(exp_old));
    m_gain[1] = 32'hF0;
    @(posedge clk); #1;
    run_frame("midgain_new", 1'b1, got);

    // Reset during MAC aborts the frame and restores default gains.
    write_gain(2, 8'h11);
    i_sample_en = 1'b1; @(posedge clk); #1;
    i_sample_en = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1;
    check("abort_state", {14'd0, o_out, o_out_valid, o_busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) m_gain[i] = 32'd128;
    m_mvol = 0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (o_out_valid) nv++; end
    check("abort_no_valid", 32'(nv), 32'd0);
    for (int i = 0; i < NCH; i++) ch_v[i] = 16'h4000;
    run_frame("abort_gain_rst", 1'b1, got);

    // Random frames against the reference model.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        write_gain(int'($urandom_range(0, NCH - 1)), 8'($urandom));
      for (int i = 0; i < NCH; i++) ch_v[i] = 16'($urandom);
      run_frame($sformatf("rand%0d", r), ($urandom_range(0, 3) != 0), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
